// File: rtl/conv_window_fetch.sv
// rtl/conv_window_fetch.sv - fetches successive KxK windows of a feature map into the PE window buffer
module conv_window_fetch #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int K      = 3,
    parameter int ADDR_W = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     mem_rd,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic [DATA_W-1:0]        mem_data,
    output logic                     win_we,
    output logic [$clog2(K*K)-1:0]   win_idx,
    output logic [DATA_W-1:0]        win_data,
    output logic                     busy,
    output logic                     done,
    output logic                     last_win
);
    localparam int IDX_W = $clog2(K*K);
    localparam int KW    = (K > 1) ? $clog2(K) : 1;
    localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    localparam logic [KW-1:0] K_LAST   = KW'(K - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - K);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - K);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [RW-1:0]      row_q, row_d;
    logic [CW-1:0]      col_q, col_d;
    logic [KW-1:0]      i_q, i_d;
    logic [KW-1:0]      j_q, j_d;
    logic               win_we_q, win_we_d;
    logic [IDX_W-1:0]   win_idx_q, win_idx_d;

    logic               rd_c;
    logic               done_c;
    logic               last_c;
    logic [ADDR_W-1:0]  addr_c;
    logic [IDX_W-1:0]   idx_c;

    assign addr_c = (ADDR_W'(row_q) + ADDR_W'(i_q)) * ADDR_W'(IMG_W)
                  + ADDR_W'(col_q) + ADDR_W'(j_q);
    assign idx_c  = IDX_W'(i_q) * IDX_W'(K) + IDX_W'(j_q);

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        i_d     = i_q;
        j_d     = j_q;
        rd_c    = 1'b0;
        done_c  = 1'b0;
        last_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                rd_c = 1'b1;
                if (j_q == K_LAST) begin
                    j_d = '0;
                    if (i_q == K_LAST) begin
                        i_d     = '0;
                        state_d = S_DRAIN;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                done_c  = 1'b1;
                state_d = S_IDLE;
                // Raster order over window origins; the last origin wraps to the top-left.
                if (col_q != COL_LAST) begin
                    col_d = col_q + 1'b1;
                end else if (row_q != ROW_LAST) begin
                    col_d = '0;
                    row_d = row_q + 1'b1;
                end else begin
                    last_c = 1'b1;
                    col_d  = '0;
                    row_d  = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        win_we_d  = rd_c;
        win_idx_d = rd_c ? idx_c : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            row_q     <= '0;
            col_q     <= '0;
            i_q       <= '0;
            j_q       <= '0;
            win_we_q  <= 1'b0;
            win_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            i_q       <= i_d;
            j_q       <= j_d;
            win_we_q  <= win_we_d;
            win_idx_q <= win_idx_d;
        end
    end

    assign mem_rd   = rd_c;
    assign mem_addr = rd_c ? addr_c : '0;
    assign win_we   = win_we_q;
    assign win_idx  = win_idx_q;
    assign win_data = mem_data;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_c;
    assign last_win = last_c;
endmodule

// File: tb/tb_conv_window_fetch.sv
// tb/tb_conv_window_fetch.sv - randomized check of conv_window_fetch against a window-sequence model
module tb_conv_window_fetch;
    localparam int DATA_W = 8;
    localparam int IMG_W  = 8;
    localparam int IMG_H  = 8;
    localparam int K      = 3;
    localparam int ADDR_W = 6;
    localparam int IDX_W  = $clog2(K*K);
    localparam int POS_W  = IMG_W - K + 1;
    localparam int NWIN   = (IMG_H - K + 1) * POS_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data = '0;
    logic              win_we;
    logic [IDX_W-1:0]  win_idx;
    logic [DATA_W-1:0] win_data;
    logic              busy;
    logic              done;
    logic              last_win;

    conv_window_fetch #(
        .DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
        .win_we(win_we), .win_idx(win_idx), .win_data(win_data),
        .busy(busy), .done(done), .last_win(last_win)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory holding mem[a] = a.
    always @(posedge clk) begin
        if (mem_rd) mem_data <= DATA_W'(mem_addr);
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ts       = -1;   // cycle in which the accepted start was seen, -1 when idle
    int wn       = 0;    // index of the window being / to be fetched in the pass
    bit post_rst = 1'b0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic int win_addr(input int w, input int n);
        int row, col;
        row = w / POS_W;
        col = w % POS_W;
        return (row + n / K) * IMG_W + col + n % K;
    endfunction

    task automatic check_outputs();
        int k;
        k = (ts >= 0) ? cyc - ts : -100;
        check_eq("mem_rd", int'(mem_rd), int'(k >= 1 && k <= K*K));
        if (k >= 1 && k <= K*K)
            check_eq("mem_addr", int'(mem_addr), win_addr(wn, k - 1));
        check_eq("win_we", int'(win_we), int'(k >= 2 && k <= K*K + 1));
        if (k >= 2 && k <= K*K + 1) begin
            check_eq("win_idx", int'(win_idx), k - 2);
            check_eq("win_data", int'(win_data), win_addr(wn, k - 2));
        end
        check_eq("busy", int'(busy), int'(k >= 1 && k <= K*K + 2));
        check_eq("done", int'(done), int'(k == K*K + 2));
        check_eq("last_win", int'(last_win), int'(k == K*K + 2 && wn == NWIN - 1));
        if (post_rst) begin
            check_eq("rst_mem_addr", int'(mem_addr), 0);
            check_eq("rst_win_idx", int'(win_idx), 0);
        end
    endtask

    // Drives start/rst for the current cycle, advances one clock and checks the next cycle.
    task automatic cycle(input bit s, input bit r);
        start = s;
        rst   = r;
        if (r) begin
            ts = -1;
            wn = 0;
        end else begin
            if (ts >= 0 && cyc > ts + K*K + 2) begin
                ts = -1;
                wn = (wn + 1) % NWIN;
            end
            if (s && ts < 0) ts = cyc;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        post_rst = r;
        check_outputs();
    endtask

    initial begin
        cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);

        // Single window from reset.
        cycle(1'b1, 1'b0);
        repeat (14) cycle(1'b0, 1'b0);

        // Extra starts during READ and on the DONE cycle are dropped.
        cycle(1'b1, 1'b0);
        for (int k = 1; k <= 12; k++) cycle(k == 4 || k == 11, 1'b0);
        repeat (3) cycle(1'b0, 1'b0);

        // Reset in the middle of a fetch, then a fresh fetch from the origin.
        cycle(1'b1, 1'b0);
        repeat (4) cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b0);
        repeat (13) cycle(1'b0, 1'b0);

        // Start held high across a full pass and beyond the wrap.
        cycle(1'b0, 1'b1);
        repeat ((K*K + 3) * (NWIN + 3)) cycle(1'b1, 1'b0);
        repeat (3) cycle(1'b0, 1'b0);

        // Random start density with occasional resets.
        for (int n = 0; n < 1500; n++)
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 199) == 0);
        repeat (14) cycle(1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
